// File: rtl/conv_tx_pkg.sv
// rtl/conv_tx_pkg.sv - shared constants and state type for conv_result_tx
package conv_tx_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int ACC_WIDTH    = 32;
  localparam int OUT_WIDTH    = 8;
  localparam int SHIFT_WIDTH  = 5;

  // Signed int8 output limits
  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - round, arithmetic shift and int8 saturation for one channel (ReLU under CONV_RESULT_TX_RELU_EN)
module requant_lane
  import conv_tx_pkg::*;
#(
  parameter int ACC_W = ACC_WIDTH
) (
  input  logic [ACC_W-1:0]       i_acc,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [OUT_WIDTH-1:0]   o_q
);

  // One extra bit of headroom so acc + rounding constant cannot wrap
  localparam logic signed [ACC_W:0] L_MAX = (ACC_W+1)'(INT8_MAX);
  localparam logic signed [ACC_W:0] L_MIN = (ACC_W+1)'(INT8_MIN);

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_rnd;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_y;

  assign w_ext = {i_acc[ACC_W-1], i_acc};
  assign w_rnd = (i_shift == '0) ? '0 : ((ACC_W+1)'(1) << (i_shift - 5'd1));
  assign w_sum = w_ext + w_rnd;
  assign w_y   = w_sum >>> i_shift;

  // Clamp the shifted value into the int8 range
  always_comb begin
    o_q = w_y[OUT_WIDTH-1:0];
`ifdef CONV_RESULT_TX_RELU_EN
    if (w_y[ACC_W]) begin
      o_q = '0;
    end else if (w_y > L_MAX) begin
      o_q = OUT_WIDTH'(INT8_MAX);
    end
`else
    if (w_y > L_MAX) begin
      o_q = OUT_WIDTH'(INT8_MAX);
    end else if (w_y < L_MIN) begin
      o_q = OUT_WIDTH'(INT8_MIN);
    end
`endif
  end

endmodule

// File: rtl/conv_result_tx.sv
// rtl/conv_result_tx.sv - requantize/pack conv results and stream them to DMA (optional ReLU: CONV_RESULT_TX_RELU_EN)
module conv_result_tx
  import conv_tx_pkg::*;
#(
  parameter int NUM_CHANNELS = conv_tx_pkg::NUM_CHANNELS,
  parameter int ACC_WIDTH    = conv_tx_pkg::ACC_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              cfg_start,
  input  logic [15:0]                       cfg_width,
  input  logic [15:0]                       cfg_height,
  input  logic [SHIFT_WIDTH-1:0]            cfg_shift,
  input  logic                              res_valid,
  input  logic [NUM_CHANNELS*ACC_WIDTH-1:0] res_data,
  output logic                              res_ready,
  output logic                              dma_valid,
  output logic [NUM_CHANNELS*OUT_WIDTH-1:0] dma_data,
  output logic                              dma_last,
  input  logic                              dma_ready,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = NUM_CHANNELS * OUT_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_t                   r_state;
  logic [31:0]              r_total;
  logic [31:0]              r_pix_cnt;
  logic [SHIFT_WIDTH-1:0]   r_shift;
  logic                     r_res_ready;
  logic                     r_busy;
  logic                     r_frame_done;

  logic                     r_stg_valid;
  logic                     r_stg_last;
  logic [DATA_W-1:0]        r_stg_data;

  logic [DATA_W-1:0]        r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    r_mem_last;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;

  logic [31:0]              w_cfg_total;
  logic                     w_accept;
  logic                     w_last_in;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_room;
  logic [DATA_W-1:0]        w_q;

  assign w_cfg_total = {16'd0, cfg_width} * {16'd0, cfg_height};
  assign w_accept    = res_valid & r_res_ready;
  assign w_last_in   = (r_pix_cnt == (r_total - 32'd1));
  assign w_pop       = dma_valid & dma_ready;
  // Stage drains into the FIFO whenever a slot exists (or one frees this cycle)
  assign w_push      = r_stg_valid & ((r_count != DEPTH_C) | w_pop);
  // Ready is registered from this value, so it lags by a cycle; the stage
  // register absorbs the one extra result that can slip in behind it.
  assign w_room      = (r_count + {{PTR_W{1'b0}}, r_stg_valid}) < DEPTH_C;

  genvar gc;
  generate
    for (gc = 0; gc < NUM_CHANNELS; gc++) begin : g_lane
      requant_lane #(
        .ACC_W (ACC_WIDTH)
      ) u_lane (
        .i_acc   (res_data[gc*ACC_WIDTH +: ACC_WIDTH]),
        .i_shift (r_shift),
        .o_q     (w_q[gc*OUT_WIDTH +: OUT_WIDTH])
      );
    end
  endgenerate

  // Frame control: configuration latch, pixel count, ready/busy/done outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_total      <= '0;
      r_pix_cnt    <= '0;
      r_shift      <= '0;
      r_res_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_res_ready <= 1'b0;
          if (cfg_start) begin
            r_total   <= w_cfg_total;
            r_shift   <= cfg_shift;
            r_pix_cnt <= '0;
            if (w_cfg_total == '0) begin
              r_frame_done <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_busy      <= 1'b1;
              r_res_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
          end
          if (w_accept && w_last_in) begin
            r_state     <= DRAIN;
            r_res_ready <= 1'b0;
          end else begin
            r_res_ready <= w_room;
          end
        end
        DRAIN: begin
          r_res_ready <= 1'b0;
          if ((r_count == '0) && !r_stg_valid) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_res_ready <= 1'b0;
        end
      endcase
    end
  end

  // Requant stage register: loads on accept, empties when it drains into the FIFO
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_last  <= 1'b0;
      r_stg_data  <= '0;
    end else if (w_accept) begin
      r_stg_valid <= 1'b1;
      r_stg_last  <= w_last_in;
      r_stg_data  <= w_q;
    end else if (w_push) begin
      r_stg_valid <= 1'b0;
    end
  end

  // Output FIFO: data plus last tag, power-of-two pointers wrap naturally
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_last <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= r_stg_data;
        r_mem_last[r_wr_ptr] <= r_stg_last;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign res_ready  = r_res_ready;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign dma_valid  = (r_count != '0);
  assign dma_data   = r_mem_data[r_rd_ptr];
  assign dma_last   = r_mem_last[r_rd_ptr];

endmodule
